dl2_mem_port: RTL and testbench
===============================

DL2_MEM_PORT -- requirements
Module: dl2_mem_port

Interface
REQ-001 Parameter ADDR_BITS, 32, memory byte-address width.
REQ-002 Parameter BLOCK_BITS, 256, L2 block width in bits.
REQ-003 Parameter SUBBLOCKS, 4, beats per block (power of 2, ≥2). BEAT_BITS=BLOCK_BITS/SUBBLOCKS; SB_LOG2=log2(SUBBLOCKS).
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  L2 block request; req_ready  out  1  request accepted this cycle.
REQ-006 req_we  in  1  1=write-back, 0=fill; req_addr  in  ADDR_BITS  byte address; req_wdata  in  BLOCK_BITS  write block.
REQ-007 resp_valid  out  1  one-cycle completion pulse; resp_we  out  1  op type; resp_rdata  out  BLOCK_BITS  fill data.
REQ-008 mem_addr  out  ADDR_BITS; mem_en  out  1; mem_we  out  1; mem_dinDstrobe  out  SB_LOG2; mem_din  out  BEAT_BITS.
REQ-009 mem_doutDstrobe  in  SB_LOG2; mem_dout  in  BEAT_BITS; mem_dready  in  1; mem_accR  in  1; mem_accW  in  1.
REQ-010 err  out  1  sticky beat-order error.

Function
REQ-011 States SHALL be IDLE, RD_ISSUE, RD_COLLECT, WR_BURST, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE with mem_accR=1 and mem_accW=1; acceptance = req_valid&&req_ready.
REQ-013 On acceptance, address SHALL be latched block-aligned (low log2(BLOCK_BITS/8) bits zeroed) and held on mem_addr until RESP exits.
REQ-014 Fill: IDLE->RD_ISSUE; mem_en=1, mem_we=0 for exactly that one cycle; then RD_COLLECT.
REQ-015 RD_COLLECT: each mem_dready cycle SHALL write mem_dout into beat slot mem_doutDstrobe; after slot SUBBLOCKS-1 is written -> RESP.
REQ-016 Write-back: IDLE->WR_BURST; SUBBLOCKS consecutive cycles mem_we=1, mem_dinDstrobe=k, mem_din=req_wdata[BEAT_BITS*(k+1)-1 -: BEAT_BITS], k=0..SUBBLOCKS-1, no gaps; then RESP.
REQ-017 mem_we SHALL never be 1 while a fill is outstanding; mem_en and mem_we never both 1.
REQ-018 RESP: resp_valid=1 for one cycle, resp_rdata = assembled block (fill) or held previous value (write); -> IDLE.
REQ-019 Fill latency: resp_valid SHALL assert one cycle after the last dready beat.
REQ-020 mem_dready outside RD_COLLECT SHALL be ignored (no data update).
REQ-021 Beat counter SHALL be SB_LOG2 bits, wrapping to 0 after SUBBLOCKS-1.
REQ-022 Back-to-back requests: next acceptance no earlier than the cycle after RESP, gated by mem_accR/mem_accW per REQ-012.

Reset
REQ-023 reset SHALL force IDLE, beat counter 0, and mem_en, mem_we, mem_dinDstrobe, resp_valid, err to 0, mem_addr to 0; resp_rdata and mem_din need no reset.
REQ-024 reset mid-burst SHALL abandon the operation; no resp_valid for it.

Configuration
REQ-025 Macro DL2_MEM_PORT_STROBE_CHECK_EN defined: in RD_COLLECT, mem_doutDstrobe != expected beat count SHALL set err (sticky until reset), and data still goes to slot mem_doutDstrobe.
REQ-026 Macro undefined: err tied 0, no checker logic.

Structure
REQ-027 Package dl2_mem_pkg SHALL hold the state enum, default ADDR_BITS/BLOCK_BITS/SUBBLOCKS constants, and derived BEAT_BITS/SB_LOG2.
REQ-028 Sub-module dl2_beat_assembler SHALL hold the read-beat register array and strobe-indexed write; FSM and write serializer stay in dl2_mem_port.

Verification (BLOCK_BITS=256, SUBBLOCKS=4, memory model read latency 5, write latency 10)
REQ-029 Fill req_addr=0x00008047 -> mem_addr=0x00008040, one-cycle mem_en, 4 dready beats, resp_rdata = stored block, resp_valid one cycle after beat 3.
REQ-030 Write-back 0x00008080, wdata=beats {0xD..,0xC..,0xB..,0xA..} -> 4 consecutive mem_we cycles, strobes 0,1,2,3, in order; readback fill returns identical block.
REQ-031 Write then immediate fill request -> req_ready held 0 until mem_accW=1 (10 cycles after last write beat); fill then completes correctly.
REQ-032 reset asserted during beat 2 of a fill -> all outputs at reset values next cycle, no resp_valid; subsequent fill succeeds.
REQ-033 With DL2_MEM_PORT_STROBE_CHECK_EN, responder sends strobes 0,2,1,3 -> err=1 and stays 1; without macro err=0 throughout.
REQ-034 Spurious mem_dready in IDLE with mem_dout=0xFFFF... -> resp_rdata unchanged, no resp_valid.

Source files
------------

// File: rtl/dl2_mem_pkg.sv
// Shared types and default geometry for the L2 block memory port.
package dl2_mem_pkg;

  localparam int DEF_ADDR_BITS  = 32;
  localparam int DEF_BLOCK_BITS = 256;
  localparam int DEF_SUBBLOCKS  = 4;
  localparam int DEF_BEAT_BITS  = DEF_BLOCK_BITS / DEF_SUBBLOCKS;
  localparam int DEF_SB_LOG2    = $clog2(DEF_SUBBLOCKS);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_COLLECT,
    WR_BURST,
    RESP
  } state_t;

endpackage

// File: rtl/dl2_beat_assembler.sv
// Read-beat register array: each accepted beat lands in the slot named by its strobe.
module dl2_beat_assembler #(
  parameter int BEAT_BITS = 64,
  parameter int SUBBLOCKS = 4,
  parameter int SB_LOG2   = 2
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [SB_LOG2-1:0]             wr_slot,
  input  logic [BEAT_BITS-1:0]           wr_data,
  output logic [BEAT_BITS*SUBBLOCKS-1:0] block
);

  logic [BEAT_BITS-1:0] beats [SUBBLOCKS];

  always_ff @(posedge clk) begin
    if (wr_en) beats[wr_slot] <= wr_data;
  end

  always_comb begin
    block = '0;
    for (int unsigned i = 0; i < SUBBLOCKS; i++) begin
      block[i*BEAT_BITS +: BEAT_BITS] = beats[i];
    end
  end

endmodule

// File: rtl/dl2_mem_port.sv
// L2 block <-> beat-wide memory port: fill collection and write-back serialization.
// Optional strobe-order checker enabled by defining DL2_MEM_PORT_STROBE_CHECK_EN.
module dl2_mem_port
  import dl2_mem_pkg::*;
#(
  parameter  int ADDR_BITS  = DEF_ADDR_BITS,
  parameter  int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter  int SUBBLOCKS  = DEF_SUBBLOCKS,
  localparam int BEAT_BITS  = BLOCK_BITS / SUBBLOCKS,
  localparam int SB_LOG2    = $clog2(SUBBLOCKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [BLOCK_BITS-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [BLOCK_BITS-1:0] resp_rdata,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [SB_LOG2-1:0]    mem_dinDstrobe,
  output logic [BEAT_BITS-1:0]  mem_din,
  input  logic [SB_LOG2-1:0]    mem_doutDstrobe,
  input  logic [BEAT_BITS-1:0]  mem_dout,
  input  logic                  mem_dready,
  input  logic                  mem_accR,
  input  logic                  mem_accW,
  output logic                  err
);

  localparam int OFF_BITS = $clog2(BLOCK_BITS / 8);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = {ADDR_BITS{1'b1}} << OFF_BITS;
  localparam logic [SB_LOG2-1:0]   LAST_BEAT  = SB_LOG2'(SUBBLOCKS - 1);

  state_t                state;
  logic [SB_LOG2-1:0]    cnt;
  logic [BLOCK_BITS-1:0] wbuf;
  logic                  accept;
  logic                  collect_beat;

  assign req_ready    = (state == IDLE) && mem_accR && mem_accW;
  assign accept       = req_valid && req_ready;
  assign collect_beat = (state == RD_COLLECT) && mem_dready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_dinDstrobe <= '0;
      resp_valid     <= 1'b0;
      resp_we        <= 1'b0;
      mem_addr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= req_addr & ALIGN_MASK;
            resp_we  <= req_we;
            cnt      <= '0;
            if (req_we) begin
              // Beat 0 goes out on the first burst cycle; the rest shift down from wbuf.
              state          <= WR_BURST;
              mem_we         <= 1'b1;
              mem_dinDstrobe <= '0;
              mem_din        <= req_wdata[BEAT_BITS-1:0];
              wbuf           <= req_wdata >> BEAT_BITS;
            end else begin
              state  <= RD_ISSUE;
              mem_en <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          mem_en <= 1'b0;
          state  <= RD_COLLECT;
        end
        RD_COLLECT: begin
          if (mem_dready) begin
            cnt <= cnt + 1'b1;
            if (mem_doutDstrobe == LAST_BEAT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (cnt == LAST_BEAT) begin
            mem_we         <= 1'b0;
            mem_dinDstrobe <= '0;
            cnt            <= '0;
            state          <= RESP;
            resp_valid     <= 1'b1;
          end else begin
            cnt            <= cnt + 1'b1;
            mem_dinDstrobe <= cnt + 1'b1;
            mem_din        <= wbuf[BEAT_BITS-1:0];
            wbuf           <= wbuf >> BEAT_BITS;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dl2_beat_assembler #(
    .BEAT_BITS (BEAT_BITS),
    .SUBBLOCKS (SUBBLOCKS),
    .SB_LOG2   (SB_LOG2)
  ) u_assembler (
    .clk     (clk),
    .wr_en   (collect_beat),
    .wr_slot (mem_doutDstrobe),
    .wr_data (mem_dout),
    .block   (resp_rdata)
  );

`ifdef DL2_MEM_PORT_STROBE_CHECK_EN
  // cnt counts beats received, so it is the strobe an in-order responder would send.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (collect_beat && (mem_doutDstrobe != cnt)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dl2_mem_port.sv
// Directed bench for dl2_mem_port with a beat-memory responder (read latency 5, write latency 10).
module tb_dl2_mem_port;

  localparam int AB = 32;
  localparam int BB = 256;
  localparam int SB = 4;
  localparam int BW = BB / SB;

`ifdef DL2_MEM_PORT_STROBE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam logic [BB-1:0] P0 = {64'h0123456789ABCDEF, 64'h1111111122222222,
                                  64'h3333333344444444, 64'hFEDCBA9876543210};
  localparam logic [BB-1:0] J1 = {4{64'h5A5A5A5A5A5A5A5A}};
  localparam logic [BB-1:0] J2 = {4{64'h0000FFFF0000FFFF}};
  localparam logic [BB-1:0] W  = {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
                                  64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD};
  localparam logic [BB-1:0] X  = {64'h0F0F0F0F0F0F0F0F, 64'h1234123412341234,
                                  64'h9876987698769876, 64'hC0FFEE00C0FFEE00};

  logic          clk, reset;
  logic          req_valid, req_ready, req_we;
  logic [AB-1:0] req_addr;
  logic [BB-1:0] req_wdata;
  logic          resp_valid, resp_we;
  logic [BB-1:0] resp_rdata;
  logic [AB-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [1:0]    mem_dinDstrobe, mem_doutDstrobe;
  logic [BW-1:0] mem_din, mem_dout;
  logic          mem_dready, mem_accR, mem_accW;
  logic          err;

  dl2_mem_port #(
    .ADDR_BITS  (AB),
    .BLOCK_BITS (BB),
    .SUBBLOCKS  (SB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_we         (resp_we),
    .resp_rdata      (resp_rdata),
    .mem_addr        (mem_addr),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_dinDstrobe  (mem_dinDstrobe),
    .mem_din         (mem_din),
    .mem_doutDstrobe (mem_doutDstrobe),
    .mem_dout        (mem_dout),
    .mem_dready      (mem_dready),
    .mem_accR        (mem_accR),
    .mem_accW        (mem_accW),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responder state, shared with the main sequence.
  logic [BB-1:0] store [16];
  logic [1:0]    order [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic          abort = 1'b0;
  logic          spur = 1'b0;
  logic [AB-1:0] exp_maddr = '0;
  logic [BB-1:0] exp_wdata = '0;
  logic          rd_busy = 1'b0;
  int            rd_timer = 0, rd_beat = 0, wr_timer = 0, wr_k = 0;
  int            last_beat_cyc = 0, last_wbeat_cyc = 0;
  logic [AB-1:0] rd_addr = '0;
  logic          prev_en = 1'b0;

  // Memory model: drives at #1 after each edge; the main sequence acts at #2.
  initial begin
    int s;
    logic [BB-1:0] tmp;
    mem_dready = 1'b0; mem_accR = 1'b1; mem_accW = 1'b1;
    mem_doutDstrobe = '0; mem_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_dready = 1'b0;
      if (abort) begin
        rd_busy = 1'b0; mem_accR = 1'b1; wr_k = 0; prev_en = 1'b0;
      end else begin
        if (spur) begin
          mem_dready = 1'b1; mem_dout = '1; mem_doutDstrobe = 2'd0;
        end
        if (mem_en) begin
          check("en_single", BB'(prev_en), BB'(1'b0));
          check("en_we_excl", BB'(mem_we), BB'(1'b0));
          check("rd_addr", BB'(mem_addr), BB'(exp_maddr));
          rd_busy = 1'b1; rd_timer = 5; rd_beat = 0; rd_addr = mem_addr; mem_accR = 1'b0;
        end else if (rd_busy) begin
          if (rd_timer > 1) rd_timer--;
          else begin
            s = int'(order[rd_beat]);
            tmp = store[rd_addr[8:5]];
            mem_dready = 1'b1;
            mem_doutDstrobe = order[rd_beat];
            mem_dout = tmp[s*BW +: BW];
            last_beat_cyc = cyc;
            rd_beat++;
            if (rd_beat == 4) begin
              rd_busy = 1'b0; mem_accR = 1'b1;
            end
          end
        end
        prev_en = mem_en;
        if (mem_we) begin
          check("wr_no_fill", BB'(rd_busy), BB'(1'b0));
          check("wr_strobe", BB'(mem_dinDstrobe), BB'(wr_k));
          check("wr_data", BB'(mem_din), BB'(exp_wdata[wr_k*BW +: BW]));
          s = int'(mem_dinDstrobe);
          tmp = store[mem_addr[8:5]];
          tmp[s*BW +: BW] = mem_din;
          store[mem_addr[8:5]] = tmp;
          mem_accW = 1'b0;
          if (wr_k == 3) begin
            wr_k = 0; wr_timer = 10; last_wbeat_cyc = cyc;
          end else wr_k++;
        end else begin
          if (wr_k != 0) begin
            check("wr_gap", BB'(mem_we), BB'(1'b1));
            wr_k = 0;
          end
          if (wr_timer > 0) begin
            wr_timer--;
            if (wr_timer == 0) mem_accW = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic          we;
    logic [AB-1:0] addr;
    logic [BB-1:0] wdata;
    logic [BB-1:0] exp_rdata;
    logic [AB-1:0] exp_maddr;
  } vec_t;

  task automatic issue(input logic we, input logic [AB-1:0] addr, input logic [BB-1:0] wdata,
                       input logic [AB-1:0] maddr, input logic after_write, output logic ok);
    int n = 0;
    exp_maddr = maddr; exp_wdata = wdata;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 60) begin tick(); n++; end
    check("accept", BB'(req_ready), BB'(1'b1));
    ok = req_ready;
    if (ok && after_write) check("accw_gate", BB'(cyc - last_wbeat_cyc), BB'(10));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic after_write);
    int n = 0;
    logic ok;
    issue(v.we, v.addr, v.wdata, v.exp_maddr, after_write, ok);
    if (!ok) return;
    while (!resp_valid && n < 40) begin tick(); n++; end
    check("resp_seen", BB'(resp_valid), BB'(1'b1));
    if (!resp_valid) return;
    check("resp_we", BB'(resp_we), BB'(v.we));
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("resp_addr", BB'(mem_addr), BB'(v.exp_maddr));
    if (!v.we) check("fill_latency", BB'(cyc - last_beat_cyc), BB'(1));
    tick();
    check("resp_pulse", BB'(resp_valid), BB'(1'b0));
  endtask

  vec_t vecs [5];

  initial begin
    logic [BB-1:0] prev;
    logic ok;
    logic saw_resp;
    int n;

    vecs[0] = '{1'b0, 32'h0000_8047, '0, P0, 32'h0000_8040};
    vecs[1] = '{1'b1, 32'h0000_8080, W,  P0, 32'h0000_8080};
    vecs[2] = '{1'b0, 32'h0000_809F, '0, W,  32'h0000_8080};
    vecs[3] = '{1'b1, 32'h0000_8105, X,  W,  32'h0000_8100};
    vecs[4] = '{1'b0, 32'h0000_8100, '0, X,  32'h0000_8100};

    for (int i = 0; i < 16; i++) store[i] = '0;
    store[2] = P0; store[4] = J1; store[8] = J2;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    check("rst_mem_en", BB'(mem_en), BB'(1'b0));
    check("rst_mem_we", BB'(mem_we), BB'(1'b0));
    check("rst_strobe", BB'(mem_dinDstrobe), BB'(2'd0));
    check("rst_resp_valid", BB'(resp_valid), BB'(1'b0));
    check("rst_err", BB'(err), BB'(1'b0));
    check("rst_mem_addr", BB'(mem_addr), BB'(32'h0));
    check("rst_req_ready", BB'(req_ready), BB'(1'b1));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], (i > 0) && vecs[i-1].we);
    end

    // Spurious beat in IDLE must not disturb the assembled block.
    prev = resp_rdata;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (2) begin
      tick();
      check("spur_rdata", resp_rdata, prev);
      check("spur_resp", BB'(resp_valid), BB'(1'b0));
    end

    // Reset while the third read beat is on the bus.
    issue(1'b0, 32'h0000_8040, '0, 32'h0000_8040, 1'b0, ok);
    n = 0;
    while (rd_beat != 3 && n < 30) begin tick(); n++; end
    check("mid_beat_reached", BB'(rd_beat), BB'(3));
    reset = 1'b1; abort = 1'b1;
    tick();
    check("mid_rst_mem_en", BB'(mem_en), BB'(1'b0));
    check("mid_rst_resp_valid", BB'(resp_valid), BB'(1'b0));
    check("mid_rst_mem_addr", BB'(mem_addr), BB'(32'h0));
    check("mid_rst_strobe", BB'(mem_dinDstrobe), BB'(2'd0));
    check("mid_rst_err", BB'(err), BB'(1'b0));
    reset = 1'b0; abort = 1'b0;
    saw_resp = 1'b0;
    repeat (12) begin
      tick();
      if (resp_valid) saw_resp = 1'b1;
    end
    check("mid_rst_no_resp", BB'(saw_resp), BB'(1'b0));
    run_vec('{1'b0, 32'h0000_8040, '0, P0, 32'h0000_8040}, 1'b0);

    // Out-of-order strobes still land in their slots.
    check("err_before", BB'(err), BB'(1'b0));
    order = '{2'd0, 2'd2, 2'd1, 2'd3};
    run_vec('{1'b0, 32'h0000_8080, '0, W, 32'h0000_8080}, 1'b0);
    check("err_set", BB'(err), BB'(ERR_EXP));
    order = '{2'd0, 2'd1, 2'd2, 2'd3};
    run_vec('{1'b0, 32'h0000_8047, '0, P0, 32'h0000_8040}, 1'b0);
    check("err_sticky", BB'(err), BB'(ERR_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
